// File: rtl/apb_dvp_regs.sv
// DVP register bank: per-channel staged/active video config, W1C status,
// frame counter and a combined registered interrupt, on an APB-style bus.

module apb_dvp_ch #(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [2:0]       idx,
   input  logic [31:0]      wdata,
   input  logic             vsync,
   input  logic             ovf,
   output logic [31:0]      rdata,
   output logic [4:0][31:0] act_o,
   output logic             irq_src
);
   // slot order: 0 CR, 1 START, 2 END, 3 SCALER, 4 THRESH
   logic [4:0][31:0] stg, act;
   logic [2:0]       sr, ier;
   logic             pend;
   logic [CNT_W-1:0] cnt;
   logic             s1, s2, s3;
   logic             rise, fall, cfg_wr, shadow, sr_wr;
   logic [4:0]       wr_slot;

   assign rise    = s2 & ~s3;
   assign fall    = ~s2 & s3;
   assign sr_wr   = we & (idx == 3'd1);
   assign cfg_wr  = |wr_slot;
   // shadow decision uses the CR value as it stands after this write
   assign shadow  = (idx == 3'd0) ? wdata[31] : stg[0][31];
   assign act_o   = act;
   assign irq_src = |(sr & ier);

   always_comb begin
      wr_slot = '0;
      if (we) begin
         case (idx)
            3'd0:    wr_slot[0] = 1'b1;
            3'd2:    wr_slot[1] = 1'b1;
            3'd3:    wr_slot[2] = 1'b1;
            3'd4:    wr_slot[3] = 1'b1;
            3'd5:    wr_slot[4] = 1'b1;
            default: wr_slot = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg  <= '0;
         act  <= '0;
         sr   <= '0;
         ier  <= '0;
         pend <= 1'b0;
         cnt  <= '0;
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
      end else begin
         s1 <= vsync;
         s2 <= s1;
         s3 <= s2;
         // commit takes the pre-edge staging; a same-edge write lands after it
         if (rise && pend) act <= stg;
         for (int i = 0; i < 5; i++) begin
            if (wr_slot[i]) begin
               stg[i] <= wdata;
               if (!shadow) act[i] <= wdata;
            end
         end
         pend <= (pend & ~rise) | (cfg_wr & shadow);
         sr   <= (sr & ~(sr_wr ? wdata[2:0] : 3'b000)) | {ovf, fall, rise};
         if (we && idx == 3'd7) ier <= wdata[2:0];
         if (we && idx == 3'd6) cnt <= '0;
         else if (rise)         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      case (idx)
         3'd0:    rdata = stg[0];
         3'd1:    rdata = {27'd0, s2, pend, sr};
         3'd2:    rdata = stg[1];
         3'd3:    rdata = stg[2];
         3'd4:    rdata = stg[3];
         3'd5:    rdata = stg[4];
         3'd6:    rdata = 32'(cnt);
         default: rdata = {29'd0, ier};
      endcase
   end
endmodule

module apb_dvp_regs #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     io_ahb_PADDR,
   input  logic                  io_ahb_PSEL,
   input  logic                  io_ahb_PENABLE,
   input  logic                  io_ahb_PWRITE,
   input  logic [31:0]           io_ahb_PWDATA,
   output logic                  io_ahb_PREADY,
   output logic [31:0]           io_ahb_PRDATA,
   output logic                  io_ahb_PSLVERROR,
   input  logic [NUM_CH-1:0]     ch_vsync,
   input  logic [NUM_CH-1:0]     ch_ovf,
   output logic [NUM_CH*32-1:0]  cfg_cr,
   output logic [NUM_CH*32-1:0]  cfg_start,
   output logic [NUM_CH*32-1:0]  cfg_end,
   output logic [NUM_CH*32-1:0]  cfg_scaler,
   output logic [NUM_CH*32-1:0]  cfg_thresh,
   output logic                  irq
);
   localparam int CH_W = ADDR_W - 3;

   logic [CH_W-1:0]               ch_sel;
   logic [2:0]                    reg_sel;
   logic                          acc, ch_ok;
   logic [NUM_CH-1:0]             lane_we, lane_irq;
   logic [NUM_CH-1:0][31:0]       lane_rd;
   logic [NUM_CH-1:0][4:0][31:0]  lane_act;

   assign ch_sel           = io_ahb_PADDR[ADDR_W-1:3];
   assign reg_sel          = io_ahb_PADDR[2:0];
   assign acc              = io_ahb_PSEL & io_ahb_PENABLE;
   assign ch_ok            = int'(ch_sel) < NUM_CH;
   assign io_ahb_PREADY    = 1'b1;
   assign io_ahb_PSLVERROR = acc & ~ch_ok;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign lane_we[g] = acc & io_ahb_PWRITE & ch_ok & (int'(ch_sel) == g);

      apb_dvp_ch #(.CNT_W(CNT_W)) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .we      (lane_we[g]),
         .idx     (reg_sel),
         .wdata   (io_ahb_PWDATA),
         .vsync   (ch_vsync[g]),
         .ovf     (ch_ovf[g]),
         .rdata   (lane_rd[g]),
         .act_o   (lane_act[g]),
         .irq_src (lane_irq[g])
      );

      assign cfg_cr[32*g +: 32]     = lane_act[g][0];
      assign cfg_start[32*g +: 32]  = lane_act[g][1];
      assign cfg_end[32*g +: 32]    = lane_act[g][2];
      assign cfg_scaler[32*g +: 32] = lane_act[g][3];
      assign cfg_thresh[32*g +: 32] = lane_act[g][4];
   end

   always_comb begin
      io_ahb_PRDATA = '0;
      if (acc && !io_ahb_PWRITE && ch_ok) begin
         for (int c = 0; c < NUM_CH; c++)
            if (int'(ch_sel) == c) io_ahb_PRDATA = lane_rd[c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq <= 1'b0;
      else        irq <= |lane_irq;
   end
endmodule
